// File: rtl/phase_pacer.sv
// Tick-phase generator for the game core: toggles o_phase every o_period cycles, speeds up on
// each apple eaten and freezes on failure/success. Define PHASE_PACER_PAUSE_EN to add i_pause.
module phase_pacer #(
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned BASE_PERIOD = 750000,
  parameter int unsigned MIN_PERIOD  = 200000,
  parameter int unsigned STEP        = 25000,
  parameter int unsigned LEVEL_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_eat,
  input  logic                i_failure,
  input  logic                i_success,
`ifdef PHASE_PACER_PAUSE_EN
  input  logic                i_pause,
`endif
  output logic                o_phase,
  output logic [LEVEL_W-1:0]  o_level,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_halted
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [PERIOD_W-1:0] BasePeriod   = PERIOD_W'(BASE_PERIOD);
  localparam logic [PERIOD_W:0]   MinPeriodExt = (PERIOD_W + 1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   StepExt      = (PERIOD_W + 1)'(STEP);
  localparam logic [LEVEL_W-1:0]  LevelMax     = '1;

  logic [0:0]          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                eat_q;
  logic                phase_q, phase_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                halted_q, halted_d;

  logic                eat_ev;
  logic                stop;
  logic                pause;
  logic                level_sat;
  logic                hit;
  logic [PERIOD_W:0]   period_sub;
  logic [PERIOD_W-1:0] period_dec;

`ifdef PHASE_PACER_PAUSE_EN
  assign pause = i_pause;
`else
  assign pause = 1'b0;
`endif

  assign eat_ev     = i_eat & ~eat_q;
  assign stop       = i_failure | i_success;
  assign level_sat  = (level_q == LevelMax);
  assign hit        = (cnt_q >= period_q - PERIOD_W'(1));
  // Extra top bit catches underflow so the floor clamp never sees a wrapped value.
  assign period_sub = {1'b0, period_q} - StepExt;
  assign period_dec = (period_sub[PERIOD_W] || (period_sub < MinPeriodExt)) ?
                      MinPeriodExt[PERIOD_W-1:0] : period_sub[PERIOD_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    level_d  = level_q;
    period_d = period_q;
    halted_d = halted_q;

    if (eat_ev && !level_sat) begin
      level_d  = level_q + LEVEL_W'(1);
      period_d = period_dec;
    end

    if (state_q == StRun) begin
      if (stop) begin
        // Halt entry wins over a coincident toggle.
        state_d  = StHalt;
        halted_d = 1'b1;
        cnt_d    = '0;
      end else if (!pause) begin
        if (hit) begin
          phase_d = ~phase_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
    end else begin
      cnt_d    = '0;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      eat_q    <= 1'b0;
      phase_q  <= 1'b0;
      level_q  <= '0;
      period_q <= BasePeriod;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eat_q    <= i_eat;
      phase_q  <= phase_d;
      level_q  <= level_d;
      period_q <= period_d;
      halted_q <= halted_d;
    end
  end

  assign o_phase  = phase_q;
  assign o_level  = level_q;
  assign o_period = period_q;
  assign o_halted = halted_q;

endmodule

// File: tb/tb_phase_pacer.sv
// Bench for phase_pacer: directed scenarios with fixed toggle edges plus random traffic checked
// against an event-level reference model every cycle.
module tb_phase_pacer;

  localparam int unsigned PW    = 8;
  localparam int unsigned LW    = 3;
  localparam int          BASE  = 16;
  localparam int          MINP  = 6;
  localparam int          STEPV = 4;
  localparam int          LMAX  = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_eat;
  logic          i_failure;
  logic          i_success;
`ifdef PHASE_PACER_PAUSE_EN
  logic          i_pause;
  localparam bit HasPause = 1'b1;
`else
  localparam bit HasPause = 1'b0;
`endif
  logic          o_phase;
  logic [LW-1:0] o_level;
  logic [PW-1:0] o_period;
  logic          o_halted;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  int toggles[$];
  logic last_phase = 1'b0;

  // Reference model: edges elapsed since the last toggle, compared against the period.
  bit m_phase, m_halted, m_eat_prev;
  int m_level, m_period, m_elapsed;

  always #5 clk = ~clk;

  phase_pacer #(
    .PERIOD_W    (PW),
    .BASE_PERIOD (BASE),
    .MIN_PERIOD  (MINP),
    .STEP        (STEPV),
    .LEVEL_W     (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_eat     (i_eat),
    .i_failure (i_failure),
    .i_success (i_success),
`ifdef PHASE_PACER_PAUSE_EN
    .i_pause   (i_pause),
`endif
    .o_phase   (o_phase),
    .o_level   (o_level),
    .o_period  (o_period),
    .o_halted  (o_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit f, input bit s, input bit p);
    bit ev;
    if (r) begin
      m_phase = 0; m_halted = 0; m_eat_prev = 0;
      m_level = 0; m_period = BASE; m_elapsed = 0;
    end else begin
      ev = e && !m_eat_prev;
      m_eat_prev = e;
      if (!m_halted) begin
        if (f || s) begin
          m_halted  = 1;
          m_elapsed = 0;
        end else if (!(p && HasPause)) begin
          m_elapsed++;
          if (m_elapsed >= m_period) begin
            m_phase   = ~m_phase;
            m_elapsed = 0;
          end
        end
      end
      if (ev && m_level < LMAX) begin
        m_level++;
        m_period = (m_period - STEPV < MINP) ? MINP : m_period - STEPV;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit f, input bit s, input bit p);
    rst = r; i_eat = e; i_failure = f; i_success = s;
`ifdef PHASE_PACER_PAUSE_EN
    i_pause = p;
`endif
    @(posedge clk);
    edge_n++;
    model_update(r, e, f, s, p);
    #1;
    if (o_phase !== last_phase) begin
      toggles.push_back(edge_n);
      last_phase = o_phase;
    end
    check("phase", {31'd0, o_phase}, {31'd0, m_phase});
    check("level", 32'(o_level), 32'(m_level));
    check("period", 32'(o_period), 32'(m_period));
    check("halted", {31'd0, o_halted}, {31'd0, m_halted});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    edge_n = 0;
    toggles.delete();
    last_phase = o_phase;
  endtask

  function automatic int tog_at(input int i);
    return (i < toggles.size()) ? toggles[i] : -1;
  endfunction

  initial begin
    int exp_p[8] = '{12, 8, 6, 6, 6, 6, 6, 6};
    bit eat_v, pause_v, r_v;
    rst = 1; i_eat = 0; i_failure = 0; i_success = 0;
`ifdef PHASE_PACER_PAUSE_EN
    i_pause = 0;
`endif

    // Reset values and free-running toggles.
    do_reset();
    check("rst_phase", {31'd0, o_phase}, 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_period", 32'(o_period), BASE);
    check("rst_halted", {31'd0, o_halted}, 0);
    idle(48);
    check("free_ntog", toggles.size(), 3);
    check("free_tog0", tog_at(0), 16);
    check("free_tog1", tog_at(1), 32);
    check("free_tog2", tog_at(2), 48);

    // Single eat pulse at edge 20.
    do_reset();
    idle(19);
    step(0, 1, 0, 0, 0);
    check("eat1_period", 32'(o_period), 12);
    check("eat1_level", 32'(o_level), 1);
    idle(20);
    check("eat1_ntog", toggles.size(), 3);
    check("eat1_tog0", tog_at(0), 16);
    check("eat1_tog1", tog_at(1), 28);
    check("eat1_tog2", tog_at(2), 40);

    // Long eat pulse counts once.
    do_reset();
    repeat (10) step(0, 1, 0, 0, 0);
    idle(2);
    check("hold_level", 32'(o_level), 1);
    check("hold_period", 32'(o_period), 12);

    // Eight pulses: period floors at MIN, level saturates.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 0);
      check("seq_period", 32'(o_period), exp_p[k]);
      check("seq_level", 32'(o_level), (k + 1 > LMAX) ? LMAX : k + 1);
      step(0, 0, 0, 0, 0);
    end

    // Period shrinks below the running count: toggle on the next edge.
    do_reset();
    idle(13);
    step(0, 1, 0, 0, 0);
    idle(13);
    check("late_tog0", tog_at(0), 15);
    check("late_tog1", tog_at(1), 27);

    // Failure on a toggle edge: halt wins, eat still applies, reset restarts.
    do_reset();
    idle(15);
    step(0, 0, 1, 0, 0);
    check("halt_phase", {31'd0, o_phase}, 0);
    step(0, 0, 1, 0, 0);
    check("halt_flag", {31'd0, o_halted}, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("halt_level", 32'(o_level), 1);
    idle(20);
    check("halt_ntog", toggles.size(), 0);
    do_reset();
    check("rerst_halted", {31'd0, o_halted}, 0);
    check("rerst_level", 32'(o_level), 0);
    check("rerst_period", 32'(o_period), BASE);
    idle(16);
    check("rerst_tog0", tog_at(0), 16);

`ifdef PHASE_PACER_PAUSE_EN
    // Pause for edges 5..14 delays the first toggle by ten edges.
    do_reset();
    idle(4);
    repeat (10) step(0, 0, 0, 0, 1);
    idle(12);
    check("pause_tog0", tog_at(0), 26);
`endif

    // Random traffic against the model.
    do_reset();
    eat_v = 0; pause_v = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) eat_v = ~eat_v;
      if ($urandom_range(0, 7) == 0) pause_v = ~pause_v;
      r_v = m_halted ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 399) == 0);
      step(r_v, eat_v, $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0, pause_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
